// File: rtl/rr_arbiter_pkg.sv
// Shared constants and types for the round-robin arbiter and its consumers.
package rr_arbiter_pkg;

  localparam int DEF_NUM_REQ    = 16;
  localparam int DEF_DATA_WIDTH = 64;

  typedef logic [DEF_NUM_REQ-1:0]         req_vec_t;
  typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/rr_arbiter_encoder.sv
// One-hot to binary encoder; an all-zero input encodes to index 0.
module encoder #(
  parameter int NUM_WIRE = 16
) (
  input  logic [NUM_WIRE-1:0]         wire_in,
  output logic [$clog2(NUM_WIRE)-1:0] index_o
);

  localparam int IDX_W = $clog2(NUM_WIRE);

  // OR-reduction of set-bit indices is exact for a one-hot input.
  always_comb begin
    index_o = '0;
    for (int i = 0; i < NUM_WIRE; i++) begin
      if (wire_in[i]) index_o = index_o | IDX_W'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin valid/ready arbiter with a one-entry registered output stage.
// Define RR_ARBITER_FIXED_PRIORITY_EN for fixed priority (lowest index wins).
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [DATA_WIDTH-1:0]           out_data_o,
  output logic [NUM_REQ-1:0]              gnt_onehot_o,
  output logic [$clog2(NUM_REQ)-1:0]      gnt_index_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic                  outValid_q, outValid_d;
  logic [DATA_WIDTH-1:0] outData_q, outData_d;
  logic [NUM_REQ-1:0]    gntOnehot_q, gntOnehot_d;
  logic [IDX_W-1:0]      ptr;

  logic [NUM_REQ-1:0]    rotated;
  logic [IDX_W-1:0]      rotIdx;
  logic [IDX_W-1:0]      offset;
  logic [IDX_W-1:0]      winner;
  logic                  anyValid;
  logic                  stageFree;
  logic                  grant;
  logic [NUM_REQ-1:0]    readyVec;
  logic [DATA_WIDTH-1:0] winData;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rotated  = '0;
    rotIdx   = '0;
    offset   = '0;
    anyValid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rotIdx     = IDX_W'(i) + ptr;
      rotated[i] = req_valid_i[rotIdx];
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset   = IDX_W'(i);
        anyValid = 1'b1;
      end
    end
    winner = offset + ptr;
  end

  always_comb begin
    stageFree = !outValid_q || out_ready_i;
    grant     = stageFree && anyValid;
    readyVec  = '0;
    winData   = '0;
    if (grant) readyVec[winner] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == winner) winData = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    gntOnehot_d = gntOnehot_q;
    if (grant) begin
      outValid_d  = 1'b1;
      outData_d   = winData;
      gntOnehot_d = readyVec;
    end else if (stageFree) begin
      outValid_d  = 1'b0;
      gntOnehot_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      gntOnehot_q <= '0;
    end else begin
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      gntOnehot_q <= gntOnehot_d;
    end
  end

`ifdef RR_ARBITER_FIXED_PRIORITY_EN
  assign ptr = '0;
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // The pointer width equals log2(NUM_REQ), so winner+1 wraps on its own.
  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = winner + IDX_W'(1);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  assign req_ready_o  = readyVec;
  assign out_valid_o  = outValid_q;
  assign out_data_o   = outData_q;
  assign gnt_onehot_o = gntOnehot_q;

  encoder #(
    .NUM_WIRE(NUM_REQ)
  ) u_encoder (
    .wire_in(gntOnehot_q),
    .index_o(gnt_index_o)
  );

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (round-robin or fixed-priority build).
module tb_rr_arbiter;
  import rr_arbiter_pkg::*;

  localparam int NR = DEF_NUM_REQ;
  localparam int DW = DEF_DATA_WIDTH;

  logic             clk = 1'b0;
  logic             arst = 1'b1;
  req_vec_t         reqValid = '0;
  logic [NR*DW-1:0] reqData = '0;
  req_vec_t         reqReady;
  logic             outValid;
  logic             outReady = 1'b0;
  logic [DW-1:0]    outData;
  req_vec_t         gntOnehot;
  req_idx_t         gntIndex;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk_i(clk),
    .arst_i(arst),
    .req_valid_i(reqValid),
    .req_data_i(reqData),
    .req_ready_o(reqReady),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .out_data_o(outData),
    .gnt_onehot_o(gntOnehot),
    .gnt_index_o(gntIndex)
  );

  task automatic applyStimulus(input req_vec_t v, input logic rdy);
    reqValid = v;
    outReady = rdy;
  endtask

  task automatic setData(input int idx, input logic [DW-1:0] val);
    reqData[idx*DW +: DW] = val;
  endtask

  task automatic resetDut();
    @(negedge clk);
    arst = 1'b1;
    applyStimulus('0, 1'b0);
    #2 arst = 1'b0;
  endtask

  // Waits for the next rising edge and checks the registered grant just after it.
  task automatic checkOutput(input string name, input int expIdx, input logic [DW-1:0] expData);
    @(posedge clk);
    #1;
    checks++;
    if (outValid !== 1'b1 || gntIndex !== req_idx_t'(expIdx) ||
        gntOnehot !== (req_vec_t'(1) << expIdx) || outData !== expData) begin
      errors++;
      $display("[TB] FAIL %s: valid=%b idx=%0d onehot=%h data=%h, expected valid=1 idx=%0d data=%h",
               name, outValid, gntIndex, gntOnehot, outData, expIdx, expData);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (outValid !== 1'b0 || outData !== '0 || gntOnehot !== '0 || gntIndex !== '0 || reqReady !== '0) begin
      errors++;
      $display("[TB] FAIL reset_initial: valid=%b data=%h onehot=%h idx=%0d ready=%h, expected all 0",
               outValid, outData, gntOnehot, gntIndex, reqReady);
    end
    resetDut();
    setData(10, 64'hDEAD_0010);
    @(negedge clk);
    applyStimulus(req_vec_t'(1) << 10, 1'b1);
    checkOutput("reset_pre_grant", 10, 64'hDEAD_0010);
    @(negedge clk);
    applyStimulus('0, 1'b0);
    #2 arst = 1'b1;
    #1;
    checks++;
    if (outValid !== 1'b0 || outData !== '0 || gntOnehot !== '0 || gntIndex !== '0 || reqReady !== '0) begin
      errors++;
      $display("[TB] FAIL reset_async: valid=%b data=%h onehot=%h idx=%0d ready=%h, expected all 0",
               outValid, outData, gntOnehot, gntIndex, reqReady);
    end
    #1 arst = 1'b0;
    setData(4, 64'h4444);
    setData(12, 64'hCCCC);
    @(negedge clk);
    applyStimulus((req_vec_t'(1) << 4) | (req_vec_t'(1) << 12), 1'b1);
    checkOutput("reset_first_grant", 4, 64'h4444);
  endtask

  task automatic test_all_valid();
    resetDut();
    for (int i = 0; i < NR; i++) setData(i, 64'h1000 + 64'(i));
    @(negedge clk);
    applyStimulus('1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if (reqReady !== (req_vec_t'(1) << (c % NR))) begin
        errors++;
        $display("[TB] FAIL all_valid_ready c=%0d: got %h expected %h", c, reqReady, req_vec_t'(1) << (c % NR));
      end
      checkOutput($sformatf("all_valid_grant c=%0d", c), c % NR, 64'h1000 + 64'(c % NR));
      @(negedge clk);
    end
  endtask

  task automatic test_single_and_skip();
    resetDut();
    setData(5, 64'h5555);
    setData(3, 64'h3333);
    @(negedge clk);
    applyStimulus(req_vec_t'(1) << 5, 1'b1);
    for (int c = 0; c < 3; c++) checkOutput($sformatf("single_req5 c=%0d", c), 5, 64'h5555);
    @(negedge clk);
    applyStimulus((req_vec_t'(1) << 3) | (req_vec_t'(1) << 5), 1'b1);
    checkOutput("skip_ptr6_req3", 3, 64'h3333);
    checkOutput("skip_then_req5", 5, 64'h5555);
  endtask

  task automatic test_backpressure();
    resetDut();
    setData(7, 64'hA5);
    setData(2, 64'h22);
    @(negedge clk);
    applyStimulus(req_vec_t'(1) << 7, 1'b1);
    checkOutput("bp_grant7", 7, 64'hA5);
    @(negedge clk);
    applyStimulus(req_vec_t'(1) << 2, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (reqReady !== '0) begin
        errors++;
        $display("[TB] FAIL bp_ready_low c=%0d: got %h expected 0", c, reqReady);
      end
      checkOutput($sformatf("bp_hold c=%0d", c), 7, 64'hA5);
      @(negedge clk);
    end
    outReady = 1'b1;
    #1;
    checks++;
    if (reqReady !== (req_vec_t'(1) << 2)) begin
      errors++;
      $display("[TB] FAIL bp_release_ready: got %h expected %h", reqReady, req_vec_t'(1) << 2);
    end
    checkOutput("bp_release_grant2", 2, 64'h22);
  endtask

  task automatic test_wrap();
    resetDut();
    setData(14, 64'hE14);
    setData(15, 64'hF15);
    setData(0, 64'h000);
    @(negedge clk);
    applyStimulus(req_vec_t'(1) << 14, 1'b1);
    checkOutput("wrap_setup14", 14, 64'hE14);
    @(negedge clk);
    applyStimulus((req_vec_t'(1) << 15) | req_vec_t'(1), 1'b1);
    checkOutput("wrap_grant15", 15, 64'hF15);
    checkOutput("wrap_grant0", 0, 64'h000);
    checkOutput("wrap_grant15_again", 15, 64'hF15);
    @(negedge clk);
    applyStimulus('0, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (outValid !== 1'b0 || gntOnehot !== '0 || gntIndex !== '0 || outData !== 64'hF15) begin
      errors++;
      $display("[TB] FAIL idle_drop: valid=%b onehot=%h idx=%0d data=%h, expected 0/0/0/f15",
               outValid, gntOnehot, gntIndex, outData);
    end
  endtask

  task automatic test_fixed_priority();
    resetDut();
    setData(2, 64'h2222);
    setData(9, 64'h9999);
    @(negedge clk);
    applyStimulus((req_vec_t'(1) << 2) | (req_vec_t'(1) << 9), 1'b1);
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (reqReady !== (req_vec_t'(1) << 2)) begin
        errors++;
        $display("[TB] FAIL fixed_ready c=%0d: got %h expected %h", c, reqReady, req_vec_t'(1) << 2);
      end
      checkOutput($sformatf("fixed_grant2 c=%0d", c), 2, 64'h2222);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
`ifdef RR_ARBITER_FIXED_PRIORITY_EN
    test_fixed_priority();
`else
    test_all_valid();
    test_single_and_skip();
    test_backpressure();
    test_wrap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
